// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 raster (25 MHz pixel clock),
//   the coordinate type used on DrawX/DrawY, and the colour-path latency of
//   the tile/sprite mappers that the sync outputs must match.
//   No ports (package).
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Address -> ROM -> colour register inside the mappers.
  localparam int MAPPER_LATENCY = 2;

  typedef logic [9:0] pix_coord_t;

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay
//   Fixed-depth shift register used to hold a sync signal back by the same
//   number of cycles the colour path takes. DEPTH = 0 is a plain wire.
//   Every stage resets to RESET_VAL so the pin shows the inactive level
//   while the pipeline refills after reset.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous reset, active low
//   d      in   undelayed signal
//   q      out  d delayed by DEPTH cycles
module vga_sync_delay #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0] pipe_q;
      logic [DEPTH-1:0] pipe_d;

      // Stage 0 takes the input; each later stage takes its predecessor.
      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q <= {DEPTH{RESET_VAL}};
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator: one pixel per vga_clk. Produces DrawX/DrawY and
//   the active-video flag for the ROM mappers, plus hs/vs for the VGA pins,
//   delayed by SYNC_DELAY cycles (0..4) so they line up with the colour
//   registers at the end of the mapper pipeline.
//   Optional feature macro: VGA_FRAME_CNT_EN adds frame_cnt and sof.
// Ports:
//   vga_clk    in   pixel clock
//   reset_n    in   asynchronous reset, active low
//   DrawX      out  horizontal pixel count (hc), no added latency
//   DrawY      out  line count (vc), no added latency
//   blank      out  1 = active video, 0 = blanking
//   hs         out  horizontal sync, active low, delayed SYNC_DELAY cycles
//   vs         out  vertical sync, active low, delayed SYNC_DELAY cycles
//   frame_cnt  out  (VGA_FRAME_CNT_EN) frames completed since reset, 16 bit
//   sof        out  (VGA_FRAME_CNT_EN) 1 on the (0,0) pixel once running
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_DELAY = MAPPER_LATENCY
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output pix_coord_t DrawX,
  output pix_coord_t DrawY,
  output logic       blank,
  output logic       hs,
`ifdef VGA_FRAME_CNT_EN
  output logic       vs,
  output logic [15:0] frame_cnt,
  output logic       sof
`else
  output logic       vs
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam pix_coord_t H_LAST     = pix_coord_t'(H_TOTAL - 1);
  localparam pix_coord_t V_LAST     = pix_coord_t'(V_TOTAL - 1);
  localparam pix_coord_t H_VIS      = pix_coord_t'(H_ACTIVE);
  localparam pix_coord_t V_VIS      = pix_coord_t'(V_ACTIVE);
  localparam pix_coord_t HS_START   = pix_coord_t'(H_ACTIVE + H_FP);
  localparam pix_coord_t HS_END     = pix_coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam pix_coord_t VS_START   = pix_coord_t'(V_ACTIVE + V_FP);
  localparam pix_coord_t VS_END     = pix_coord_t'(V_ACTIVE + V_FP + V_SYNC);

  pix_coord_t hc_q, hc_d;
  pix_coord_t vc_q, vc_d;
  logic       run_q, run_d;
  logic       h_wrap, v_wrap;
  logic       hs_raw, vs_raw;

  // Wrap compares use >= so a corrupted count still returns to the raster
  // on the next cycle instead of running through the whole 10-bit range.
  always_comb begin
    h_wrap = (hc_q >= H_LAST);
    v_wrap = (vc_q >= V_LAST);
    hc_d   = h_wrap ? '0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + 10'd1;
    end
    // run masks blank on the reset cycle so the first visible pixel
    // follows the first real clock edge.
    run_d  = 1'b1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q  <= '0;
      vc_q  <= '0;
      run_q <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      run_q <= run_d;
    end
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;
  assign blank = run_q & (hc_q < H_VIS) & (vc_q < V_VIS);

  // vs is a whole-line decode of vc, so it changes together with hc = 0.
  assign hs_raw = ~((hc_q >= HS_START) & (hc_q < HS_END));
  assign vs_raw = ~((vc_q >= VS_START) & (vc_q < VS_END));

  vga_sync_delay #(
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(1'b1)
  ) u_hs_delay (
    .clk  (vga_clk),
    .rst_n(reset_n),
    .d    (hs_raw),
    .q    (hs)
  );

  vga_sync_delay #(
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(1'b1)
  ) u_vs_delay (
    .clk  (vga_clk),
    .rst_n(reset_n),
    .d    (vs_raw),
    .q    (vs)
  );

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the (last,last) -> (0,0) step; rolls over from 65535 to 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (h_wrap && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign sof       = run_q & (hc_q == '0) & (vc_q == '0);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen. dut0 uses the default 640x480@60 timing;
//   dut1 uses a shrunken raster (80 x 55, sync delay 3) so whole frames fit
//   in a short run. A reference model advances on every clock edge and
//   queues the expected outputs; they are popped and compared on the
//   falling edge. Directed measurements cover line/frame structure, sync
//   placement, mid-frame asynchronous reset and (with VGA_FRAME_CNT_EN)
//   the frame counter and start-of-frame pulse.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
  localparam int W = 40;
`else
  localparam int W = 23;
`endif

  // Index 0: default timing, index 1: small raster.
  localparam int HA  [2] = '{640, 64};
  localparam int HFP [2] = '{16, 4};
  localparam int HSW [2] = '{96, 8};
  localparam int HBP [2] = '{48, 4};
  localparam int VA  [2] = '{480, 48};
  localparam int VFP [2] = '{10, 2};
  localparam int VSW [2] = '{2, 2};
  localparam int VBP [2] = '{33, 3};
  localparam int SD  [2] = '{2, 3};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [9:0]  x0, y0, x1, y1;
  logic        b0, hs0, vs0, b1, hs1, vs1;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc0, fc1;
  logic        sof0, sof1;
`endif

  vga_timing_gen dut0 (
    .vga_clk  (clk),
    .reset_n  (rst_n),
    .DrawX    (x0),
    .DrawY    (y0),
    .blank    (b0),
    .hs       (hs0),
`ifdef VGA_FRAME_CNT_EN
    .vs       (vs0),
    .frame_cnt(fc0),
    .sof      (sof0)
`else
    .vs       (vs0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(3)
  ) dut1 (
    .vga_clk  (clk),
    .reset_n  (rst_n),
    .DrawX    (x1),
    .DrawY    (y1),
    .blank    (b1),
    .hs       (hs1),
`ifdef VGA_FRAME_CNT_EN
    .vs       (vs1),
    .frame_cnt(fc1),
    .sof      (sof1)
`else
    .vs       (vs1)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mhc [2];
  int mvc [2];
  bit mrun[2];
  bit mhh [2][4];
  bit mvh [2][4];
  int mfc [2];

  function automatic bit raw_hs(input int i, input int h);
    return !(h >= HA[i] + HFP[i] && h < HA[i] + HFP[i] + HSW[i]);
  endfunction

  function automatic bit raw_vs(input int i, input int v);
    return !(v >= VA[i] + VFP[i] && v < VA[i] + VFP[i] + VSW[i]);
  endfunction

  task automatic model_reset(input int i);
    mhc[i]  = 0;
    mvc[i]  = 0;
    mrun[i] = 1'b0;
    mfc[i]  = 0;
    for (int k = 0; k < 4; k++) begin
      mhh[i][k] = 1'b1;
      mvh[i][k] = 1'b1;
    end
  endtask

  task automatic model_step(input int i);
    bit rh, rv;
    int ht, vt;
    ht = HA[i] + HFP[i] + HSW[i] + HBP[i];
    vt = VA[i] + VFP[i] + VSW[i] + VBP[i];
    rh = raw_hs(i, mhc[i]);
    rv = raw_vs(i, mvc[i]);
    for (int k = 3; k > 0; k--) begin
      mhh[i][k] = mhh[i][k-1];
      mvh[i][k] = mvh[i][k-1];
    end
    mhh[i][0] = rh;
    mvh[i][0] = rv;
    if (mhc[i] == ht - 1) begin
      mhc[i] = 0;
      if (mvc[i] == vt - 1) begin
        mvc[i] = 0;
        mfc[i] = (mfc[i] + 1) % 65536;
      end else begin
        mvc[i] = mvc[i] + 1;
      end
    end else begin
      mhc[i] = mhc[i] + 1;
    end
    mrun[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] model_out(input int i);
    logic [W-1:0] r;
    r        = '0;
    r[22:13] = 10'(mhc[i]);
    r[12:3]  = 10'(mvc[i]);
    r[2]     = mrun[i] && (mhc[i] < HA[i]) && (mvc[i] < VA[i]);
    r[1]     = (SD[i] == 0) ? raw_hs(i, mhc[i]) : mhh[i][SD[i]-1];
    r[0]     = (SD[i] == 0) ? raw_vs(i, mvc[i]) : mvh[i][SD[i]-1];
`ifdef VGA_FRAME_CNT_EN
    r[23]    = mrun[i] && (mhc[i] == 0) && (mvc[i] == 0);
    r[39:24] = 16'(mfc[i]);
`endif
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] e0, e1;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else        model_step(i);
    end
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
  end

  always @(negedge clk) begin
    if (exp_q0.size() != 0) begin
      e0 = exp_q0.pop_front();
      check("d0_drawx", 32'(x0),  32'(e0[22:13]));
      check("d0_drawy", 32'(y0),  32'(e0[12:3]));
      check("d0_blank", 32'(b0),  32'(e0[2]));
      check("d0_hs",    32'(hs0), 32'(e0[1]));
      check("d0_vs",    32'(vs0), 32'(e0[0]));
`ifdef VGA_FRAME_CNT_EN
      check("d0_sof",   32'(sof0), 32'(e0[23]));
      check("d0_fcnt",  32'(fc0),  32'(e0[39:24]));
`endif
    end
    if (exp_q1.size() != 0) begin
      e1 = exp_q1.pop_front();
      check("d1_drawx", 32'(x1),  32'(e1[22:13]));
      check("d1_drawy", 32'(y1),  32'(e1[12:3]));
      check("d1_blank", 32'(b1),  32'(e1[2]));
      check("d1_hs",    32'(hs1), 32'(e1[1]));
      check("d1_vs",    32'(vs1), 32'(e1[0]));
`ifdef VGA_FRAME_CNT_EN
      check("d1_sof",   32'(sof1), 32'(e1[23]));
      check("d1_fcnt",  32'(fc1),  32'(e1[39:24]));
`endif
    end
  end

  // ---------------- driver / directed checks ----------------
  task automatic check_reset_values(input string tag);
    check({tag, "_d0_x"},  32'(x0),  0);
    check({tag, "_d0_y"},  32'(y0),  0);
    check({tag, "_d0_b"},  32'(b0),  0);
    check({tag, "_d0_hs"}, 32'(hs0), 1);
    check({tag, "_d0_vs"}, 32'(vs0), 1);
    check({tag, "_d1_x"},  32'(x1),  0);
    check({tag, "_d1_y"},  32'(y1),  0);
    check({tag, "_d1_b"},  32'(b1),  0);
    check({tag, "_d1_hs"}, 32'(hs1), 1);
    check({tag, "_d1_vs"}, 32'(vs1), 1);
`ifdef VGA_FRAME_CNT_EN
    check({tag, "_d1_fc"},  32'(fc1),  0);
    check({tag, "_d1_sof"}, 32'(sof1), 0);
`endif
  endtask

  initial begin
    int found;
    int blank_cnt, hs_cnt, hs_first, hs_last;
    int cyc, lines, vs_cnt, vf_x, vf_y, vl_x, vl_y;

    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_values("rst");
    #1 rst_n = 1'b1;

    // First edge after release: counters have advanced and video is live.
    @(posedge clk);
    #1;
    check("first_edge_d0_x", 32'(x0), 1);
    check("first_edge_d0_b", 32'(b0), 1);
    check("first_edge_d1_x", 32'(x1), 1);
    check("first_edge_d1_b", 32'(b1), 1);

    // One full default line (line 1): blank width, hs width and placement.
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (y0 == 10'd1 && x0 == 10'd0) found = 1;
    end
    check("wait_d0_line1", found, 1);
    blank_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) @(negedge clk);
      if (b0) blank_cnt++;
      if (!hs0) begin
        if (hs_first < 0) hs_first = int'(x0);
        hs_last = int'(x0);
        hs_cnt++;
      end
    end
    check("d0_line_end_x", 32'(x0), 799);
    @(negedge clk);
    check("d0_wrap_x", 32'(x0), 0);
    check("d0_wrap_y", 32'(y0), 2);
    check("d0_blank_width", blank_cnt, 640);
    check("d0_hs_width", hs_cnt, 96);
    check("d0_hs_first_x", hs_first, 658);
    check("d0_hs_last_x", hs_last, 753);

    // One full small frame: length, line count, vs placement.
    found = 0;
    for (int c = 0; c < 5000 && found == 0; c++) begin
      @(negedge clk);
      if (y1 == 10'd0 && x1 == 10'd0) found = 1;
    end
    check("wait_d1_frame", found, 1);
    cyc = 0; lines = 0; vs_cnt = 0; vf_x = -1; vf_y = -1; vl_x = -1; vl_y = -1;
    do begin
      if (x1 == 10'd0) lines++;
      if (!vs1) begin
        if (vf_x < 0) begin
          vf_x = int'(x1);
          vf_y = int'(y1);
        end
        vl_x = int'(x1);
        vl_y = int'(y1);
        vs_cnt++;
      end
      @(negedge clk);
      cyc++;
    end while (!(x1 == 10'd0 && y1 == 10'd0) && cyc < 5000);
    check("d1_frame_cycles", cyc, 4400);
    check("d1_frame_lines", lines, 55);
    check("d1_vs_width", vs_cnt, 160);
    check("d1_vs_first_y", vf_y, 50);
    check("d1_vs_first_x", vf_x, 3);
    check("d1_vs_last_y", vl_y, 52);
    check("d1_vs_last_x", vl_x, 2);

    // Mid-frame reset: outputs must clear without a clock edge.
    found = 0;
    for (int c = 0; c < 5000 && found == 0; c++) begin
      @(negedge clk);
      if (y1 == 10'd20 && x1 == 10'd30) found = 1;
    end
    check("wait_d1_midframe", found, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_d1_x", 32'(x1), 1);
    check("restart_d1_y", 32'(y1), 0);
    check("restart_d1_b", 32'(b1), 1);

`ifdef VGA_FRAME_CNT_EN
    // Three small frames: sof spacing and final frame count.
    begin
      int sof_cnt, last_sof;
      sof_cnt = 0; last_sof = 0; cyc = 0;
      while (sof_cnt < 3 && cyc < 4 * 4400 + 100) begin
        @(negedge clk);
        cyc++;
        if (sof1) begin
          if (sof_cnt > 0) check("d1_sof_gap", cyc - last_sof, 4400);
          last_sof = cyc;
          sof_cnt++;
        end
      end
      check("d1_sof_count", sof_cnt, 3);
      check("d1_frame_cnt", 32'(fc1), 3);
      check("d0_frame_cnt", 32'(fc0), 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
